// File: rtl/alu_arbiter_if.sv
// One requester's link to the ALU arbiter: a valid/ready request channel for
// the operation and a valid/ready response channel for the result and flags.
interface alu_arbiter_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FUN_W  = 6;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_A;
    logic [DATA_W-1:0] req_B;
    logic [FUN_W-1:0]  req_ALUFun;
    logic              req_Sign;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_out;
    logic              rsp_Zero;
    logic              rsp_Overflow;
    logic              rsp_Negative;

    modport master (
        output req_valid, req_A, req_B, req_ALUFun, req_Sign, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_Zero, rsp_Overflow, rsp_Negative
    );

    modport slave (
        input  req_valid, req_A, req_B, req_ALUFun, req_Sign, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_Zero, rsp_Overflow, rsp_Negative
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// one registered execute cycle per op, one-deep response slot per port.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    alu_arbiter_if.slave p0,
    alu_arbiter_if.slave p1,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [5:0]  alu_ALUFun,
    output logic        alu_Sign,
    input  logic [31:0] alu_out,
    input  logic        alu_Zero,
    input  logic        alu_Overflow,
    input  logic        alu_Negative
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FUN_W  = 6;

    logic              op_valid;
    logic              op_owner;
    logic [DATA_W-1:0] op_A;
    logic [DATA_W-1:0] op_B;
    logic [FUN_W-1:0]  op_ALUFun;
    logic              op_Sign;
    logic              last_grant;

    logic [1:0]        slot_valid;
    logic [DATA_W-1:0] slot_out [2];
    logic [1:0]        slot_zero;
    logic [1:0]        slot_ovf;
    logic [1:0]        slot_neg;

    logic [1:0] req_valid;
    logic [1:0] rsp_ready;
    logic [1:0] eligible;
    logic [1:0] ready;
    logic [1:0] accept;

    assign req_valid = {p1.req_valid, p0.req_valid};
    assign rsp_ready = {p1.rsp_ready, p0.rsp_ready};

    // A port may issue when it has nothing executing and its slot is free
    // by the next edge (empty now, or being drained this cycle).
    assign eligible[0] = ~(op_valid & ~op_owner) & (~slot_valid[0] | rsp_ready[0]);
    assign eligible[1] = ~(op_valid &  op_owner) & (~slot_valid[1] | rsp_ready[1]);

    // Yield only when the other port is also a contender and this port won last.
    assign ready[0] = eligible[0] & ~(req_valid[1] & eligible[1] & ~last_grant);
    assign ready[1] = eligible[1] & ~(req_valid[0] & eligible[0] &  last_grant);
    assign accept   = req_valid & ready;

    assign p0.req_ready = ready[0];
    assign p1.req_ready = ready[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            op_valid   <= 1'b0;
            op_owner   <= 1'b0;
            op_A       <= '0;
            op_B       <= '0;
            op_ALUFun  <= '0;
            op_Sign    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept != 2'b00) begin
            op_valid   <= 1'b1;
            op_owner   <= accept[1];
            last_grant <= accept[1];
            op_A       <= accept[1] ? p1.req_A      : p0.req_A;
            op_B       <= accept[1] ? p1.req_B      : p0.req_B;
            op_ALUFun  <= accept[1] ? p1.req_ALUFun : p0.req_ALUFun;
            op_Sign    <= accept[1] ? p1.req_Sign   : p0.req_Sign;
        end else begin
            op_valid   <= 1'b0;
        end
    end

    // Drain then fill; eligibility keeps a fill off a slot still being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid  <= 2'b00;
            slot_out[0] <= '0;
            slot_out[1] <= '0;
            slot_zero   <= 2'b00;
            slot_ovf    <= 2'b00;
            slot_neg    <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (slot_valid[i] && rsp_ready[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
            if (op_valid) begin
                slot_valid[op_owner] <= 1'b1;
                slot_out[op_owner]   <= alu_out;
                slot_zero[op_owner]  <= alu_Zero;
                slot_ovf[op_owner]   <= alu_Overflow;
                slot_neg[op_owner]   <= alu_Negative;
            end
        end
    end

    assign alu_A      = op_valid ? op_A      : '0;
    assign alu_B      = op_valid ? op_B      : '0;
    assign alu_ALUFun = op_valid ? op_ALUFun : '0;
    assign alu_Sign   = op_valid & op_Sign;

    assign p0.rsp_valid    = slot_valid[0];
    assign p0.rsp_out      = slot_out[0];
    assign p0.rsp_Zero     = slot_zero[0];
    assign p0.rsp_Overflow = slot_ovf[0];
    assign p0.rsp_Negative = slot_neg[0];

    assign p1.rsp_valid    = slot_valid[1];
    assign p1.rsp_out      = slot_out[1];
    assign p1.rsp_Zero     = slot_zero[1];
    assign p1.rsp_Overflow = slot_ovf[1];
    assign p1.rsp_Negative = slot_neg[1];
endmodule
